// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, opcodes and NOP encoding for the MIPS pipeline
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Opcodes whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - combinational load-use hazard detector for the IF/ID boundary
module hazard_unit
    import mips_pkg::*;
(
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              pcsrc,
    input  logic              ext_stall,
    output logic              hazard,
    output logic              bubble,
    output logic              pc_write
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (idex_rt == id_rs);
    assign rt_match = uses_rt(id_opcode) && (idex_rt == id_rt);

    // A load into $zero never produces a value, so it cannot be a hazard source.
    assign hazard   = id_valid && idex_memread && (idex_rt != '0) && (rs_match || rt_match);

    // A taken branch squashes the stalled instruction, so no bubble is needed.
    assign bubble   = hazard && !pcsrc;
    assign pc_write = !(hazard && !pcsrc) && !ext_stall;

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with field slicing and load-use stall control
module if_id_stage #(
    parameter int          DATA_W    = mips_pkg::DATA_W,
    parameter int          REG_AW    = mips_pkg::REG_AW,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_fetch_pc,
    input  logic [DATA_W-1:0] i_fetch_instr,
    input  logic              i_pcsrc,
    input  logic              i_ext_stall,
    input  logic              i_idex_memread,
    input  logic [REG_AW-1:0] i_idex_rt,
    output logic              o_pcWrite,
    output logic              o_bubble,
    output logic              o_id_valid,
    output logic [DATA_W-1:0] o_id_pc,
    output logic [DATA_W-1:0] o_id_pc_plus4,
    output logic [DATA_W-1:0] o_id_instr,
    output logic [5:0]        o_id_opcode,
    output logic [REG_AW-1:0] o_id_rs,
    output logic [REG_AW-1:0] o_id_rt,
    output logic [REG_AW-1:0] o_id_rd,
    output logic [4:0]        o_id_shamt,
    output logic [5:0]        o_id_funct,
    output logic [15:0]       o_id_imm
);

    logic hazard;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_id_pc    <= '0;
            o_id_instr <= DATA_W'(NOP_INSTR);
            o_id_valid <= 1'b0;
        end else if (i_ext_stall) begin
            o_id_pc    <= o_id_pc;
            o_id_instr <= o_id_instr;
            o_id_valid <= o_id_valid;
        end else if (i_pcsrc) begin
            o_id_pc    <= i_fetch_pc;
            o_id_instr <= DATA_W'(NOP_INSTR);
            o_id_valid <= 1'b0;
        end else if (hazard) begin
            o_id_pc    <= o_id_pc;
            o_id_instr <= o_id_instr;
            o_id_valid <= o_id_valid;
        end else begin
            o_id_pc    <= i_fetch_pc;
            o_id_instr <= i_fetch_instr;
            o_id_valid <= 1'b1;
        end
    end

    assign o_id_pc_plus4 = o_id_pc + DATA_W'(4);

    assign o_id_opcode = o_id_instr[31:26];
    assign o_id_rs     = o_id_instr[25:21];
    assign o_id_rt     = o_id_instr[20:16];
    assign o_id_rd     = o_id_instr[15:11];
    assign o_id_shamt  = o_id_instr[10:6];
    assign o_id_funct  = o_id_instr[5:0];
    assign o_id_imm    = o_id_instr[15:0];

    hazard_unit u_hazard_unit (
        .id_valid     (o_id_valid),
        .id_opcode    (o_id_opcode),
        .id_rs        (o_id_rs),
        .id_rt        (o_id_rt),
        .idex_memread (i_idex_memread),
        .idex_rt      (i_idex_rt),
        .pcsrc        (i_pcsrc),
        .ext_stall    (i_ext_stall),
        .hazard       (hazard),
        .bubble       (o_bubble),
        .pc_write     (o_pcWrite)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed table-driven bench for if_id_stage
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        pcsrc;
    logic        ext_stall;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic        pc_write;
    logic        bubble;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_stage dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fetch_pc     (fetch_pc),
        .i_fetch_instr  (fetch_instr),
        .i_pcsrc        (pcsrc),
        .i_ext_stall    (ext_stall),
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .o_pcWrite      (pc_write),
        .o_bubble       (bubble),
        .o_id_valid     (id_valid),
        .o_id_pc        (id_pc),
        .o_id_pc_plus4  (id_pc_plus4),
        .o_id_instr     (id_instr),
        .o_id_opcode    (id_opcode),
        .o_id_rs        (id_rs),
        .o_id_rt        (id_rt),
        .o_id_rd        (id_rd),
        .o_id_shamt     (id_shamt),
        .o_id_funct     (id_funct),
        .o_id_imm       (id_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pcsrc;
        logic        ext;
        logic        memread;
        logic [4:0]  rt;
        logic        e_pcw;
        logic        e_bub;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic pcs, input logic ext, input logic mr,
                                input logic [4:0] rt, input logic e_pcw, input logic e_bub,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_instr);
        vec_t v;
        v.pc = pc; v.instr = instr; v.pcsrc = pcs; v.ext = ext; v.memread = mr; v.rt = rt;
        v.e_pcw = e_pcw; v.e_bub = e_bub; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic pcs,
                         input logic ext, input logic mr, input logic [4:0] rt);
        @(negedge clk);
        fetch_pc = pc; fetch_instr = instr; pcsrc = pcs;
        ext_stall = ext; idex_memread = mr; idex_rt = rt;
    endtask

    initial begin
        // pre-edge: pcWrite, bubble   post-edge: valid, pc, instr
        vecs[0]  = mk(32'h00, 32'h2001_0005, 0, 0, 0, 5'd0, 1, 0, 1, 32'h00, 32'h2001_0005);
        vecs[1]  = mk(32'h04, 32'h0022_1820, 0, 0, 0, 5'd0, 1, 0, 1, 32'h04, 32'h0022_1820);
        vecs[2]  = mk(32'h08, 32'hAC03_0000, 0, 0, 1, 5'd2, 0, 1, 1, 32'h04, 32'h0022_1820);
        vecs[3]  = mk(32'h08, 32'hAC03_0000, 0, 0, 0, 5'd2, 1, 0, 1, 32'h08, 32'hAC03_0000);
        vecs[4]  = mk(32'h0C, 32'h0022_1820, 0, 0, 0, 5'd0, 1, 0, 1, 32'h0C, 32'h0022_1820);
        vecs[5]  = mk(32'h10, 32'h8C22_0004, 1, 0, 1, 5'd2, 1, 0, 0, 32'h10, 32'h0000_0000);
        vecs[6]  = mk(32'h40, 32'h2001_0005, 0, 0, 1, 5'd0, 1, 0, 1, 32'h40, 32'h2001_0005);
        vecs[7]  = mk(32'h44, 32'h2022_0005, 0, 0, 1, 5'd0, 1, 0, 1, 32'h44, 32'h2022_0005);
        vecs[8]  = mk(32'h48, 32'h8C22_0004, 0, 0, 1, 5'd2, 1, 0, 1, 32'h48, 32'h8C22_0004);
        vecs[9]  = mk(32'h4C, 32'h0000_0000, 0, 0, 1, 5'd1, 0, 1, 1, 32'h48, 32'h8C22_0004);
        vecs[10] = mk(32'h100, 32'h1111_1111, 0, 1, 0, 5'd0, 0, 0, 1, 32'h48, 32'h8C22_0004);
        vecs[11] = mk(32'h100, 32'h1111_1111, 1, 1, 0, 5'd0, 0, 0, 1, 32'h48, 32'h8C22_0004);
        vecs[12] = mk(32'h100, 32'h1111_1111, 0, 1, 1, 5'd1, 0, 1, 1, 32'h48, 32'h8C22_0004);
        vecs[13] = mk(32'hFFFF_FFFC, 32'h0022_1820, 0, 0, 0, 5'd0, 1, 0, 1, 32'hFFFF_FFFC, 32'h0022_1820);

        rst_n = 1'b0; fetch_pc = 32'h0; fetch_instr = 32'h8C22_0004;
        pcsrc = 1'b0; ext_stall = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(id_valid), 32'd0);
        check("reset_instr", id_instr, 32'h0);
        check("reset_pc", id_pc, 32'h0);
        check("reset_pcwrite", 32'(pc_write), 32'd1);
        check("reset_bubble", 32'(bubble), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pc, vecs[i].instr, vecs[i].pcsrc, vecs[i].ext, vecs[i].memread, vecs[i].rt);
            #1;
            check($sformatf("v%0d_pcwrite", i), 32'(pc_write), 32'(vecs[i].e_pcw));
            check($sformatf("v%0d_bubble", i), 32'(bubble), 32'(vecs[i].e_bub));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_pc", i), id_pc, vecs[i].e_pc);
            check($sformatf("v%0d_instr", i), id_instr, vecs[i].e_instr);
        end

        // ID now holds add $3,$1,$2 at the top of the address space
        check("wrap_pc_plus4", id_pc_plus4, 32'h0000_0000);
        check("add_opcode", 32'(id_opcode), 32'h00);
        check("add_rs", 32'(id_rs), 32'd1);
        check("add_rt", 32'(id_rt), 32'd2);
        check("add_rd", 32'(id_rd), 32'd3);
        check("add_shamt", 32'(id_shamt), 32'd0);
        check("add_funct", 32'(id_funct), 32'h20);
        check("add_imm", 32'(id_imm), 32'h1820);

        drive(32'h04, 32'h0022_1820, 0, 0, 0, 5'd0);
        @(posedge clk);
        #1;
        check("pc4_plus4", id_pc_plus4, 32'h08);

        drive(32'h08, 32'h2022_0005, 0, 0, 0, 5'd0);
        @(posedge clk);
        #1;
        check("addi_opcode", 32'(id_opcode), 32'h08);
        check("addi_imm", 32'(id_imm), 32'h0005);

        // reset asserted during an ext stall and a pending flush still wins
        drive(32'h20, 32'hAC03_0000, 1, 1, 1, 5'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_stall_valid", 32'(id_valid), 32'd0);
        check("rst_stall_pc", id_pc, 32'h0);
        check("rst_stall_instr", id_instr, 32'h0);
        drive(32'h20, 32'hAC03_0000, 0, 0, 1, 5'd1);
        rst_n = 1'b1;
        #1;
        check("rst_stall_pcwrite", 32'(pc_write), 32'd1);
        check("rst_stall_bubble", 32'(bubble), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(id_valid), 32'd1);
        check("post_rst_instr", id_instr, 32'hAC03_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
